// File: rtl/bcd_entry_pkg.sv
// Shared definitions for the keypad amount-entry block: button indices, FSM states and BCD digit helpers.
package bcd_entry_pkg;

    localparam int BTN_C = 4;
    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_L = 1;
    localparam int BTN_R = 0;

    typedef enum logic [1:0] {EDIT, COMMIT, RELEASE} state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t d);
        return (d == 4'd0 || d > BCD_MAX) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_amount_entry_if.sv
// Keypad-side bundle: ms tick, raw buttons and clear in; BCD amount, cursor and commit strobe out.
interface bcd_amount_entry_if;
    logic        tick_1ms;
    logic [4:0]  btn_i;
    logic        clear_i;
    logic [31:0] data_o;
    logic [2:0]  cursor_o;
    logic        flag_o;

    modport master (output tick_1ms, btn_i, clear_i, input data_o, cursor_o, flag_o);
    modport slave  (input tick_1ms, btn_i, clear_i, output data_o, cursor_o, flag_o);
endinterface

// File: rtl/bcd_amount_entry_btn_debounce.sv
// Single button: 2-FF synchronizer, tick-sampled debounce counter, rising-edge press pulse.
// Latency: 2 clk sync + DEBOUNCE_MS stable ticks; pulse is high the cycle the debounced level rises.
// Backpressure: none, free-running.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic db,
    output logic pls
);
    logic [1:0] sync;
    logic [7:0] cnt;
    logic       db_q;
    logic       db_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b00;
            cnt  <= 8'd0;
            db_q <= 1'b0;
            db_d <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            db_d <= db_q;
            if (tick) begin
                // Any sample agreeing with the debounced level restarts the count.
                if (sync[1] != db_q) begin
                    if (cnt == 8'(DEBOUNCE_MS - 1)) begin
                        db_q <= ~db_q;
                        cnt  <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end else begin
                    cnt <= 8'd0;
                end
            end
        end
    end

    assign db  = db_q;
    assign pls = db_q & ~db_d;
endmodule

// File: rtl/bcd_amount_entry.sv
// Keypad front end: five debounced buttons edit an 8-digit packed-BCD amount; center commits with a 1-clk flag.
// Latency: edit lands one clk after the debounced press pulse; auto-repeat under BCD_ENTRY_AUTO_REPEAT_EN.
// Backpressure: none; presses are ignored in COMMIT/RELEASE until center is released.
module bcd_amount_entry
    import bcd_entry_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 150
) (
    input  logic clk,
    input  logic rst,
    bcd_amount_entry_if.slave bus
);
    localparam logic [2:0] CUR_MAX = 3'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255 ||
        REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_bad_cfg
        $error("bcd_amount_entry: parameter out of range");
    end

    logic [4:0] db;
    logic [4:0] pls;
    logic [4:0] evt;
    logic       db_unused;

    state_t       state, state_n;
    bcd_t [7:0]   digits, digits_n;
    logic [2:0]   cursor, cursor_n;

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn (
            .clk  (clk),
            .rst  (rst),
            .tick (bus.tick_1ms),
            .btn  (bus.btn_i[i]),
            .db   (db[i]),
            .pls  (pls[i])
        );
    end

    assign db_unused = ^db;

`ifdef BCD_ENTRY_AUTO_REPEAT_EN
    localparam logic [15:0] REP_DLY  = 16'(REPEAT_DELAY_MS);
    localparam logic [15:0] REP_RATE = 16'(REPEAT_RATE_MS);

    logic [15:0] rep_cnt;
    logic        rep_first;
    logic        rep_pls;
    logic        rep_hold;

    assign rep_hold = (state == EDIT) && (db[BTN_U] || db[BTN_D]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt   <= 16'd0;
            rep_first <= 1'b1;
            rep_pls   <= 1'b0;
        end else begin
            rep_pls <= 1'b0;
            if (!rep_hold || (|pls)) begin
                rep_cnt   <= 16'd0;
                rep_first <= 1'b1;
            end else if (bus.tick_1ms) begin
                if (rep_cnt + 16'd1 == (rep_first ? REP_DLY : REP_RATE)) begin
                    rep_pls   <= 1'b1;
                    rep_cnt   <= 16'd0;
                    rep_first <= 1'b0;
                end else begin
                    rep_cnt <= rep_cnt + 16'd1;
                end
            end
        end
    end

    // A repeat acts on up when held, otherwise on down, matching press priority.
    assign evt = pls | {1'b0, rep_pls & db[BTN_U], rep_pls & ~db[BTN_U] & db[BTN_D], 2'b00};
`else
    assign evt = pls;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EDIT;
            digits <= '0;
            cursor <= 3'd0;
        end else begin
            state  <= state_n;
            digits <= digits_n;
            cursor <= cursor_n;
        end
    end

    always_comb begin
        state_n  = state;
        digits_n = digits;
        cursor_n = cursor;
        case (state)
            EDIT: begin
                if (bus.clear_i) begin
                    digits_n = '0;
                    cursor_n = 3'd0;
                end else if (evt[BTN_C]) begin
                    state_n = COMMIT;
                end else if (evt[BTN_U]) begin
                    digits_n[cursor] = bcd_inc(digits[cursor]);
                end else if (evt[BTN_D]) begin
                    digits_n[cursor] = bcd_dec(digits[cursor]);
                end else if (evt[BTN_L]) begin
                    cursor_n = (cursor >= CUR_MAX) ? 3'd0 : cursor + 3'd1;
                end else if (evt[BTN_R]) begin
                    cursor_n = (cursor == 3'd0) ? CUR_MAX : cursor - 3'd1;
                end
            end
            COMMIT: begin
                digits_n = '0;
                cursor_n = 3'd0;
                state_n  = RELEASE;
            end
            RELEASE: begin
                if (bus.clear_i) begin
                    digits_n = '0;
                    cursor_n = 3'd0;
                end
                if (!db[BTN_C]) begin
                    state_n = EDIT;
                end
            end
            default: state_n = EDIT;
        endcase
    end

    assign bus.data_o   = digits;
    assign bus.cursor_o = cursor;
    assign bus.flag_o   = (state == COMMIT);
endmodule

// File: doc/bcd_amount_entry.md
Name: bcd_amount_entry

Overview:
- Front-end keypad stage on the system clock that turns the five raw board push-buttons into an 8-digit packed-BCD amount plus a one-cycle commit strobe.
- Replaces slow-clock button sampling with a tick-enabled synchronizer and debouncer.
- data_o / flag_o feed the mode/register datapath directly; data_o also drives the seven-segment display path while editing.

Parameters:
- NUM_DIGITS, 8, number of editable BCD digits (1..8); digits at and above NUM_DIGITS are forced to 0.
- DEBOUNCE_MS, 20, consecutive stable tick_1ms samples required before a button is accepted (1..255).
- REPEAT_DELAY_MS, 500, hold time before auto-repeat starts (only with AUTO_REPEAT_EN).
- REPEAT_RATE_MS, 150, auto-repeat period (only with AUTO_REPEAT_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- tick_1ms  in  1  one-clk-wide enable, once per ms.
- btn_i  in  5  raw buttons {center, up, down, left, right} = bits [4:0].
- clear_i  in  1  synchronous clear of the entry, one cycle.
- data_o  out  32  packed BCD amount; digit k in bits [4k+3:4k].
- cursor_o  out  3  index of the digit under edit (0 = least significant).
- flag_o  out  1  commit strobe, exactly one clk cycle.

Behaviour:
- Reset (rst=0, asynchronous): data_o=0, cursor_o=0, flag_o=0, FSM=EDIT, all debounced states=0, all counters=0, synchronizers cleared.
- Sync: each btn_i bit passes a 2-FF synchronizer on clk.
- Debounce: per button, sampled only on tick_1ms. Counter increments while the synced value differs from the debounced value and resets to 0 when they match. When the counter reaches DEBOUNCE_MS, the debounced value toggles and the counter clears.
- Edge detect: a 0->1 change of a debounced value yields a one-cycle press pulse in the same clk cycle.
- Priority when several pulses share a cycle: center > up > down > left > right; lower-priority pulses in that cycle are discarded.
- FSM states: EDIT, COMMIT, RELEASE.
  - EDIT:
    - up: digit[cursor] +1, wraps 9->0.
    - down: digit[cursor] -1, wraps 0->9.
    - left: cursor +1, wraps NUM_DIGITS-1 -> 0.
    - right: cursor -1, wraps 0 -> NUM_DIGITS-1.
    - Each edit is applied in the clk edge following the press pulse (latency 1 from debounced edge).
    - center: -> COMMIT.
  - COMMIT: flag_o=1 for this single cycle with data_o holding the committed amount, unchanged. Next cycle: data_o<=0, cursor_o<=0, -> RELEASE.
  - RELEASE: all presses ignored until the center debounced value is 0, then -> EDIT. This prevents double commit.
- clear_i: in EDIT or RELEASE, data_o<=0 and cursor_o<=0 next cycle, with priority over any press in that cycle. clear_i in COMMIT is ignored (flag_o still fires).
- Digits never leave 0..9; no carry between digits.
- flag_o is never asserted in two consecutive cycles.

Optional Feature:
- Macro: BCD_ENTRY_AUTO_REPEAT_EN.
- Defined: while up or down stays debounced-high in EDIT, after REPEAT_DELAY_MS ticks a repeat pulse fires, then one every REPEAT_RATE_MS ticks. A repeat pulse has the same effect and priority as a fresh press. The counter restarts on release or when another button is pressed.
- Undefined: one action per debounced press; repeat counters are not generated.

Decomposition:
- Shared package bcd_entry_pkg:
  - button index constants BTN_C=4, BTN_U=3, BTN_D=2, BTN_L=1, BTN_R=0.
  - FSM state enum {EDIT, COMMIT, RELEASE}.
  - BCD digit typedef (4 bits).
  - constant BCD_MAX=9.
- One natural sub-module, btn_debounce: a single-button synchronizer + debounce counter + rising-edge pulse, instantiated 5 times.

Test Plan:
- Reset: rst=0 mid-edit with data_o=0x00000042 -> all outputs 0 within the same cycle; after release, no flag_o.
- Bounce: up toggles every 3 ms for 15 ms, then holds high 25 ms, DEBOUNCE_MS=20 -> digit0 goes 0->1 exactly once.
- Edit and wrap:
  - down at digit0=0 -> 9.
  - left x8 from cursor 0 -> cursor back to 0.
  - entry up,up,left,up -> data_o=0x00000012.
- Commit: center with data_o=0x00000250 -> flag_o high exactly one cycle with data_o=0x00000250; next cycle data_o=0, cursor_o=0. Center held 2 s -> no second flag_o.
- Simultaneous: up and left debounced in the same cycle -> only digit increments, cursor unchanged. clear_i together with up -> data_o=0.
- Auto-repeat (macro defined): up held 1000 ms from digit0=0 -> increments at 0 (press), 500, 650, 800, 950 ms -> digit0=5. Macro undefined -> digit0=1.
